// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic pipeline register with a two-entry skid buffer.
// It uses a valid/ready handshake, and in_ready is fully registered except for flush.
// A synchronous flush drops all held entries and inserts a bubble.
// Optional feature, macro PIPE_STAGE_ELASTIC_STATS_EN: adds saturating stall_cnt and flush_cnt outputs.
module pipe_stage_elastic #(
    parameter int                 WIDTH  = 96,
    parameter logic [WIDTH-1:0]   BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [7:0]       flush_cnt
`endif
);

    logic             r_main_vld;
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_acc;
    logic             w_con;

    // The skid register is the only thing that can block input.
    // Flush also blocks input, so a word taken in the flush cycle is never dropped silently.
    assign in_ready  = !r_skid_vld && !flush;
    assign w_acc     = in_valid && in_ready;
    assign w_con     = r_main_vld && out_ready;
    assign out_valid = r_main_vld;
    assign out_data  = r_main_data;

    // Occupancy/data update. Empty slots always hold BUBBLE, so out_data needs no mux.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main_vld  <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_main_data <= BUBBLE;
            r_skid_data <= BUBBLE;
        end else if (!r_main_vld) begin
            if (w_acc) begin
                r_main_vld  <= 1'b1;
                r_main_data <= in_data;
            end
        end else if (!r_skid_vld) begin
            if (w_acc && w_con) begin
                r_main_data <= in_data;
            end else if (w_acc) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= in_data;
            end else if (w_con) begin
                r_main_vld  <= 1'b0;
                r_main_data <= BUBBLE;
            end
        end else if (w_con) begin
            r_main_data <= r_skid_data;
            r_skid_vld  <= 1'b0;
            r_skid_data <= BUBBLE;
        end
    end

`ifdef PIPE_STAGE_ELASTIC_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [7:0]  r_flush_cnt;

    // Saturating event counters. Only rst clears them, so they keep counting through flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_main_vld && !out_ready && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (flush && r_flush_cnt != 8'hFF)
                r_flush_cnt <= r_flush_cnt + 8'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic. Expected values are hand-computed.
// It uses a non-zero BUBBLE so that empty slots can be told apart from data.
module tb_pipe_stage_elastic;

    localparam int             W   = 96;
    localparam logic [W-1:0]   BUB = 96'h5A5A;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
    logic [15:0]  stall_cnt;
    logic [7:0]   flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(W), .BUBBLE(BUB)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge. Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        in_valid = v; in_data = d; out_ready = r;
        #1;
    endtask

    task automatic fill_ab();
        drive(1'b1, 96'hA, 1'b0); step();
        drive(1'b1, 96'hB, 1'b0); step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0; #1;
        chk("rst_vld",   W'(out_valid), W'(0));
        chk("rst_data",  out_data, BUB);
        chk("rst_rdy",   W'(in_ready), W'(1));

        // Streaming at full rate
        drive(1'b1, 96'h1, 1'b1);
        chk("s1_rdy", W'(in_ready), W'(1)); step();
        drive(1'b1, 96'h2, 1'b1);
        chk("s1_out", out_data, 96'h1); chk("s1_vld", W'(out_valid), W'(1));
        chk("s2_rdy", W'(in_ready), W'(1)); step();
        drive(1'b1, 96'h3, 1'b1);
        chk("s2_out", out_data, 96'h2); chk("s3_rdy", W'(in_ready), W'(1)); step();
        drive(1'b0, 96'h0, 1'b1);
        chk("s3_out", out_data, 96'h3); step();
        chk("s_empty_vld",  W'(out_valid), W'(0));
        chk("s_empty_data", out_data, BUB);

        // Backpressure: A and B are absorbed, then C is refused
        drive(1'b1, 96'hA, 1'b0); chk("bp_rdyA", W'(in_ready), W'(1)); step();
        drive(1'b1, 96'hB, 1'b0); chk("bp_rdyB", W'(in_ready), W'(1)); step();
        drive(1'b1, 96'hC, 1'b0); chk("bp_rdyC", W'(in_ready), W'(0));
        chk("bp_headA", out_data, 96'hA); step();
        chk("bp_stable", out_data, 96'hA);
        drive(1'b1, 96'hC, 1'b1); chk("bp_full_rdy", W'(in_ready), W'(0));
        chk("bp_outA", out_data, 96'hA); step();
        drive(1'b1, 96'hC, 1'b1); chk("bp_rdy_again", W'(in_ready), W'(1));
        chk("bp_outB", out_data, 96'hB); step();
        drive(1'b0, 96'h0, 1'b1); chk("bp_outC", out_data, 96'hC); step();
        chk("bp_empty", W'(out_valid), W'(0));

        // Flush while FULL, with D offered in the flush cycle
        fill_ab();
        drive(1'b1, 96'hD, 1'b1); flush = 1'b1; #1;
        chk("fl_rdy", W'(in_ready), W'(0)); step();
        flush = 1'b0; drive(1'b0, 96'h0, 1'b1);
        chk("fl_vld",  W'(out_valid), W'(0));
        chk("fl_data", out_data, BUB);
        chk("fl_rdy1", W'(in_ready), W'(1)); step();
        chk("fl_noD_vld",  W'(out_valid), W'(0));
        chk("fl_noD_data", out_data, BUB);

        // rst together with flush while FULL
        fill_ab();
        chk("rf_full", W'(in_ready), W'(0));
        rst = 1'b1; flush = 1'b1; step();
        rst = 1'b0; flush = 1'b0; drive(1'b0, 96'h0, 1'b0);
        chk("rf_vld",  W'(out_valid), W'(0));
        chk("rf_data", out_data, BUB);
        chk("rf_rdy",  W'(in_ready), W'(1));
`ifdef PIPE_STAGE_ELASTIC_STATS_EN
        chk("rf_stall", W'(stall_cnt), W'(0));
        chk("rf_flush", W'(flush_cnt), W'(0));

        // Saturate stall_cnt with a held entry, then count flush pulses
        drive(1'b1, 96'h7, 1'b0); step();
        drive(1'b0, 96'h0, 1'b0);
        for (int i = 0; i < 70000; i++) step();
        chk("st_sat", W'(stall_cnt), W'(16'hFFFF));
        chk("st_head", out_data, 96'h7);
        for (int i = 0; i < 3; i++) begin
            flush = 1'b1; step();
            flush = 1'b0; step();
        end
        chk("fc_3",     W'(flush_cnt), W'(3));
        chk("fc_stall", W'(stall_cnt), W'(16'hFFFF));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
